// File: rtl/mcmem_pkg.sv
// Shared definitions for the multi-cycle memory controller.
//   state_t : 2-bit FSM state encoding (IDLE, WAIT, RESP, FAULT)
//   CNT_W   : width of the wait-state down-counter (covers 0..15)
package mcmem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RESP  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

endpackage

// File: rtl/mcmem_ctrl_ram1p.sv
// Single-port synchronous word RAM.
// Ports:
//   i_clk   : clock, writes and reads happen on the rising edge
//   i_rst   : async active-high reset, clears only the read-data register
//   i_we    : write enable (word write of i_wdata at i_addr)
//   i_re    : read enable (loads o_rdata from i_addr)
//   i_addr  : word index
//   i_wdata : write data
//   o_rdata : registered read data, holds between reads
module ram1p #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [0:DEPTH_WORDS-1];
  logic [31:0] r_rdata;

  // Storage is deliberately never reset so contents survive a controller reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // The read register doubles as the CPU-visible read data, so it is reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mcmem_ctrl.sv
// Multi-cycle memory controller: accepts one CPU access at a time, inserts
// WAIT_CYCLES wait states, then completes it against a single-port RAM.
// Ports:
//   clock   : clock, rising edge
//   reset   : async active-high reset (aborts any access in flight)
//   req     : access request, only looked at while idle
//   madr    : byte address (must be word aligned and inside the RAM)
//   tomem   : write data
//   wmem    : 1 = write, 0 = read
//   frommem : registered read data, changes only on a successful read
//   ready   : one-cycle completion pulse
//   err     : one-cycle pulse with ready for a faulted access
//   busy    : controller is not idle
module mcmem_ctrl
  import mcmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] madr,
  input  logic [31:0] tomem,
  input  logic        wmem,
  output logic [31:0] frommem,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [AW-1:0]    r_idx;
  logic [31:0]      r_wdata;
  logic             r_wmem;

  logic             w_fault;
  logic             w_accept;
  logic             w_commit;
  logic [AW-1:0]    w_ram_idx;
  logic [31:0]      w_ram_wdata;
  logic             w_ram_wmem;
  logic             w_ram_we;
  logic             w_ram_re;

  // Misaligned or out-of-range addresses fault; the upper address bits only
  // matter here, the RAM itself sees just the low index bits.
  assign w_fault  = (madr[1:0] != 2'b00) || ({2'b00, madr[31:2]} >= DEPTH_LIM);
  assign w_accept = (r_state == S_IDLE) && req;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_commit   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          if (w_fault) begin
            w_next = S_FAULT;
          end else if (WAIT_CYCLES == 0) begin
            w_next   = S_RESP;
            w_commit = 1'b1;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        // Counter was loaded with WAIT_CYCLES, so leaving at 1 gives exactly
        // WAIT_CYCLES cycles in this state.
        if (r_cnt <= CNT_W'(1)) begin
          w_next     = S_RESP;
          w_cnt_next = '0;
          w_commit   = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      S_RESP:  w_next = S_IDLE;
      S_FAULT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Access operands captured at acceptance; the CPU may change its outputs
  // freely afterwards.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_idx   <= madr[AW+1:2];
      r_wdata <= tomem;
      r_wmem  <= wmem;
    end
  end

  // With zero wait states the commit edge is the acceptance edge itself, so
  // the RAM must see the live inputs while idle.
  assign w_ram_idx   = (r_state == S_IDLE) ? madr[AW+1:2] : r_idx;
  assign w_ram_wdata = (r_state == S_IDLE) ? tomem        : r_wdata;
  assign w_ram_wmem  = (r_state == S_IDLE) ? wmem         : r_wmem;
  assign w_ram_we    = w_commit &&  w_ram_wmem;
  assign w_ram_re    = w_commit && !w_ram_wmem;

  ram1p #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_idx),
    .i_wdata (w_ram_wdata),
    .o_rdata (frommem)
  );

  assign ready = (r_state == S_RESP) || (r_state == S_FAULT);
  assign err   = (r_state == S_FAULT);
  assign busy  = (r_state != S_IDLE);

endmodule
